// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: NOP encoding, PC source select, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // addi x0, x0, 0 -- canonical bubble instruction
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // 2'b11 is reserved and behaves as PC_SEQ
    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JALR = 2'b10
    } pcsrc_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: pc_f+4, branch target or jalr target (bit0 cleared), word aligned.
// Latency: combinational.
// Backpressure: none; the caller decides when the selected PC is applied.
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [31:0] i_pc_f,
    input  logic [1:0]  i_pcsrc,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_jalr_target,
    output logic [31:0] o_next_pc,
    output logic        o_redirect,
    output logic        o_misalign
);

    logic [31:0] w_jalr_clr;

    assign w_jalr_clr = {i_jalr_target[31:1], 1'b0};

    // pick the target; misalignment is judged before the low bits are forced to zero
    always_comb begin
        o_next_pc  = i_pc_f + 32'd4;
        o_redirect = 1'b0;
        o_misalign = 1'b0;
        if (i_pcsrc == PC_BR) begin
            o_next_pc  = {i_br_target[31:2], 2'b00};
            o_redirect = 1'b1;
            o_misalign = (i_br_target[1:0] != 2'b00);
        end else if (i_pcsrc == PC_JALR) begin
            o_next_pc  = {w_jalr_clr[31:2], 2'b00};
            o_redirect = 1'b1;
            o_misalign = w_jalr_clr[1];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem read, IF/ID register with one-word skid buffer.
// Latency: 2 cycles per instruction with zero-wait memory (req, then response loads IF/ID).
// Backpressure: stall freezes IF/ID and parks a returning word in the buffer; redirects override stall.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCsrc,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        inst_valid,
    output logic        misalign_err
);

    fetch_state_t r_state;
    logic [31:0]  r_pc_f;
    logic         r_imem_req;
    logic [31:0]  r_inst;
    logic [31:0]  r_pc_d;
    logic [31:0]  r_pc_plus4_d;
    logic         r_inst_valid;
    logic         r_misalign;
    logic [31:0]  r_buf;
    logic         r_buf_valid;

    logic [31:0]  w_next_pc;
    logic         w_redirect;
    logic         w_misalign;

    pc_next_sel u_pc_next_sel (
        .i_pc_f        (r_pc_f),
        .i_pcsrc       (PCsrc),
        .i_br_target   (br_target),
        .i_jalr_target (jalr_target),
        .o_next_pc     (w_next_pc),
        .o_redirect    (w_redirect),
        .o_misalign    (w_misalign)
    );

    // fetch FSM with IF/ID register; all outputs registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc_f       <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_inst       <= NOP_INST;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd4;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_buf        <= NOP_INST;
            r_buf_valid  <= 1'b0;
        end else begin
            r_imem_req <= 1'b0;
            r_misalign <= 1'b0;
            // decode is free and nothing is delivered unless overridden below: bubble
            if (!stall) begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end
            if (w_redirect) begin
                r_pc_f       <= w_next_pc;
                r_misalign   <= w_misalign;
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
                r_buf_valid  <= 1'b0;
                // a response still owed by memory must be swallowed before refetching;
                // one arriving this very cycle is simply dropped
                if (r_state == REQ ||
                    ((r_state == WAIT || r_state == DRAIN) && !imem_rvalid)) begin
                    r_state <= DRAIN;
                end else begin
                    r_state    <= REQ;
                    r_imem_req <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= REQ;
                        r_imem_req <= 1'b1;
                    end
                    REQ: begin
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (!stall) begin
                                r_inst       <= imem_rdata;
                                r_inst_valid <= 1'b1;
                                r_pc_d       <= r_pc_f;
                                r_pc_plus4_d <= w_next_pc;
                                r_pc_f       <= w_next_pc;
                                r_state      <= REQ;
                                r_imem_req   <= 1'b1;
                            end else begin
                                r_buf       <= imem_rdata;
                                r_buf_valid <= 1'b1;
                                r_state     <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            r_inst       <= r_buf;
                            r_inst_valid <= r_buf_valid;
                            r_pc_d       <= r_pc_f;
                            r_pc_plus4_d <= w_next_pc;
                            r_pc_f       <= w_next_pc;
                            r_buf_valid  <= 1'b0;
                            r_state      <= REQ;
                            r_imem_req   <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (imem_rvalid) begin
                            r_state    <= REQ;
                            r_imem_req <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_pc_f;
    assign Inst         = r_inst;
    assign pc_d         = r_pc_d;
    assign pc_plus4_d   = r_pc_plus4_d;
    assign inst_valid   = r_inst_valid;
    assign misalign_err = r_misalign;

endmodule
